multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Moore-style control sequencer for the multi-cycle build of the processor. A unified instruction/data memory and a shared ALU are reused across cycles, with an instruction register holding the current instruction. The block decodes opcode/funct from that instruction register and steps the datapath through fetch, decode, execute, memory and writeback states. It inserts wait states until the memory signals ready.

## Interface
- No parameters.
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; forces state FETCH and clears Illegal.
- Opcode  in  6  Instr[31:26] from the instruction register; stable from DECODE onward.
- Funct  in  6  Instr[5:0] from the instruction register.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC load enable.
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  instruction register load.
- MemWrite  out  1  memory write request.
- HalfWord  out  1  16-bit memory access.
- RegDst  out  1  destination: 0 = rt, 1 = rd.
- MemtoReg  out  1  writeback source: 0 = ALUOut, 1 = memory data.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- Shift  out  1  ALU operand is shamt (sll/srl).
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt, 011 sll, 100 srl.
- Illegal  out  1  sticky; set on an undecodable instruction.
- State  out  4  current state code, for debug.

## Operation
- Supported instructions:
  - R-type (op 000000) with funct add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, srl 000010.
  - lw 100011, lh 100001, sw 101011, sh 101001, beq 000100, addi 001000, j 000010.
- Any output not listed for a state is 0. ALUControl defaults to 010.
- States (code) and transitions:
  - FETCH(0): ALUSrcB=01, ALUControl=add. IRWrite=PCWrite=MemReady. Stay until MemReady=1, then DECODE.
  - DECODE(1): ALUSrcB=11, add. Next state by instruction:
    - loads/stores → MEMADR
    - legal R-type → EXECUTE
    - beq → BRANCH
    - addi → ADDIEX
    - j → JUMP
    - anything else → FETCH, and set Illegal.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, add. HalfWord=1 for lh/sh. Next: loads → MEMREAD, stores → MEMWRITE.
  - MEMREAD(3): IorD=1, HalfWord per opcode. Stay until MemReady=1, then MEMWB.
  - MEMWB(4): MemtoReg=1, RegWrite=1, HalfWord per opcode. Next FETCH.
  - MEMWRITE(5): IorD=1, MemWrite=1, HalfWord per opcode. Stay until MemReady=1, then FETCH.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUControl from funct, Shift=1 for sll/srl. Next ALUWB.
  - ALUWB(7): RegDst=1, RegWrite=1. Next FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, PCWrite=Zero. Next FETCH.
  - ADDIEX(9): ALUSrcA=1, ALUSrcB=10, add. Next ADDIWB(10).
  - ADDIWB(10): RegWrite=1. Next FETCH.
  - JUMP(11): PCSrc=10, PCWrite=1. Next FETCH.
- Codes 12–15 are unreachable. If entered, go to FETCH with all enables 0.
- Illegal clears only on reset.

## Timing
- The state register is the only storage besides Illegal. Outputs are combinational from State, plus MemReady/Zero gating.
- Cycles per instruction with MemReady tied high:
  - R-type 4, lw/lh 5, sw/sh 4, addi 4, beq 3, j 3, illegal 2.
- Each low cycle of MemReady in FETCH, MEMREAD or MEMWRITE adds one cycle.
- MemWrite stays high for every MEMWRITE cycle. Memory commits exactly once, on the cycle MemReady=1.
- Reset asserted mid-instruction: state becomes FETCH immediately (asynchronous). All write enables drop in that cycle, so no partial RegWrite or MemWrite.
- After reset: State=0, Illegal=0. Outputs show FETCH values: ALUSrcB=01, ALUControl=010, all enables 0 while MemReady=0.

## Test plan
- Reset, then add (op 0, funct 100000), MemReady=1 → States 0,1,6,7,0. RegWrite=1 with RegDst=1 only in cycle 4.
- lw with MemReady low for 2 cycles in MEMREAD → States 0,1,2,3,3,3,4,0. RegWrite+MemtoReg exactly once.
- sh (101001) with MemReady=1 → MEMWRITE for one cycle with MemWrite=1, HalfWord=1, IorD=1.
- beq with Zero=1, then beq with Zero=0 → PCWrite=1 with PCSrc=01 in BRANCH for the first, PCWrite=0 for the second. Both take 3 cycles.
- Opcode 111111 → DECODE returns to FETCH and Illegal=1. Illegal persists through a following j (PCSrc=10, PCWrite=1) and clears only on reset.
- reset driven low during MEMWRITE with MemReady=0 → State=0 and MemWrite=0 immediately, with no wait for the clock edge.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Moore-style control sequencer for the multi-cycle datapath.
// Steps fetch/decode/execute/memory/writeback, stalling on MemReady in memory states.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       HalfWord,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       Shift,
  output logic [2:0] ALUControl,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpLh    = 6'b100001;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpSh    = 6'b101001;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;
  localparam logic [2:0] AluSll = 3'b011;
  localparam logic [2:0] AluSrl = 3'b100;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiEx   = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  // Instruction decode from the instruction register fields.
  logic       is_load, is_store, is_half;
  logic       rtype_ok;
  logic [2:0] funct_alu;
  logic       funct_shift;

  assign is_load  = (Opcode == OpLw) || (Opcode == OpLh);
  assign is_store = (Opcode == OpSw) || (Opcode == OpSh);
  assign is_half  = (Opcode == OpLh) || (Opcode == OpSh);

  always_comb begin
    rtype_ok    = 1'b1;
    funct_alu   = AluAdd;
    funct_shift = 1'b0;
    case (Funct)
      6'b100000: funct_alu = AluAdd;
      6'b100010: funct_alu = AluSub;
      6'b100100: funct_alu = AluAnd;
      6'b100101: funct_alu = AluOr;
      6'b101010: funct_alu = AluSlt;
      6'b000000: begin
        funct_alu   = AluSll;
        funct_shift = 1'b1;
      end
      6'b000010: begin
        funct_alu   = AluSrl;
        funct_shift = 1'b1;
      end
      default: rtype_ok = 1'b0;
    endcase
  end

  // Raw controls before the reset gating of write enables.
  logic       pc_write, ir_write, mem_write, reg_write;
  logic       iord, half_word, reg_dst, mem_to_reg, alu_src_a, shift;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    iord       = 1'b0;
    half_word  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    shift      = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_ctrl   = AluAdd;

    case (state_q)
      StFetch: begin
        alu_src_b = 2'b01;
        ir_write  = MemReady;
        pc_write  = MemReady;
        if (MemReady) state_d = StDecode;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        if (is_load || is_store)                  state_d = StMemAdr;
        else if (Opcode == OpRtype && rtype_ok)   state_d = StExecute;
        else if (Opcode == OpBeq)                 state_d = StBranch;
        else if (Opcode == OpAddi)                state_d = StAddiEx;
        else if (Opcode == OpJ)                   state_d = StJump;
        else begin
          state_d   = StFetch;
          illegal_d = 1'b1;
        end
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        half_word = is_half;
        state_d   = is_load ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        iord      = 1'b1;
        half_word = is_half;
        if (MemReady) state_d = StMemWb;
      end
      StMemWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        half_word  = is_half;
        state_d    = StFetch;
      end
      StMemWrite: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        half_word = is_half;
        if (MemReady) state_d = StFetch;
      end
      StExecute: begin
        alu_src_a = 1'b1;
        alu_ctrl  = funct_alu;
        shift     = funct_shift;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_ctrl  = AluSub;
        pc_src    = 2'b01;
        pc_write  = Zero;
        state_d   = StFetch;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StJump: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Hold every write enable low while reset is asserted, so an aborted access never commits.
  assign PCWrite    = pc_write & reset;
  assign IRWrite    = ir_write & reset;
  assign MemWrite   = mem_write & reset;
  assign RegWrite   = reg_write & reset;
  assign IorD       = iord;
  assign HalfWord   = half_word;
  assign RegDst     = reg_dst;
  assign MemtoReg   = mem_to_reg;
  assign ALUSrcA    = alu_src_a;
  assign ALUSrcB    = alu_src_b;
  assign PCSrc      = pc_src;
  assign Shift      = shift;
  assign ALUControl = alu_ctrl;
  assign Illegal    = illegal_q;
  assign State      = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: each instruction is expanded into an expected per-cycle step list
// from the instruction's class and the chosen MemReady stalls, then replayed against the DUT.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode, Funct;
  logic       Zero, MemReady;
  logic       PCWrite, IorD, IRWrite, MemWrite, HalfWord, RegDst, MemtoReg, RegWrite;
  logic       ALUSrcA, Shift, Illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .IorD(IorD), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .HalfWord(HalfWord), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .Shift(Shift), .ALUControl(ALUControl), .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {PCWrite, IorD, IRWrite, MemWrite, HalfWord, RegDst, MemtoReg, RegWrite,
                ALUSrcA, ALUSrcB, PCSrc, Shift, ALUControl};

  typedef struct packed {
    logic [3:0]  st;
    logic        rdy;
    logic [16:0] o;
  } step_t;

  step_t q[$];
  int    n_pass = 0;
  int    n_total = 0;
  bit    illegal_m = 1'b0;

  // f = {PCWrite, IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA}
  function automatic logic [16:0] po(input logic [7:0] f, input logic hw, input logic [1:0] sb,
                                     input logic [1:0] ps, input logic sh, input logic [2:0] alu);
    return {f[7:4], hw, f[3:0], sb, ps, sh, alu};
  endfunction

  function automatic step_t mk(input logic [3:0] st, input logic rdy, input logic [16:0] o);
    return {st, rdy, o};
  endfunction

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                       input int fw, input int mw, output bit ill);
    logic       hw, ld, st, is_r, sh;
    logic [2:0] alu;
    q.delete();
    ill  = 1'b0;
    hw   = (op == 6'h21) || (op == 6'h29);
    ld   = (op == 6'h23) || (op == 6'h21);
    st   = (op == 6'h2b) || (op == 6'h29);
    is_r = 1'b0;
    sh   = 1'b0;
    alu  = 3'b010;
    if (op == 6'h00) begin
      is_r = 1'b1;
      case (fn)
        6'h20: alu = 3'b010;
        6'h22: alu = 3'b110;
        6'h24: alu = 3'b000;
        6'h25: alu = 3'b001;
        6'h2a: alu = 3'b111;
        6'h00: begin alu = 3'b011; sh = 1'b1; end
        6'h02: begin alu = 3'b100; sh = 1'b1; end
        default: is_r = 1'b0;
      endcase
    end
    for (int i = 0; i < fw; i++)
      q.push_back(mk(4'd0, 1'b0, po(8'b0000_0000, 1'b0, 2'b01, 2'b00, 1'b0, 3'b010)));
    q.push_back(mk(4'd0, 1'b1, po(8'b1010_0000, 1'b0, 2'b01, 2'b00, 1'b0, 3'b010)));
    q.push_back(mk(4'd1, rnd(), po(8'b0000_0000, 1'b0, 2'b11, 2'b00, 1'b0, 3'b010)));
    if (ld || st) begin
      q.push_back(mk(4'd2, rnd(), po(8'b0000_0001, hw, 2'b10, 2'b00, 1'b0, 3'b010)));
      if (ld) begin
        for (int i = 0; i < mw; i++)
          q.push_back(mk(4'd3, 1'b0, po(8'b0100_0000, hw, 2'b00, 2'b00, 1'b0, 3'b010)));
        q.push_back(mk(4'd3, 1'b1, po(8'b0100_0000, hw, 2'b00, 2'b00, 1'b0, 3'b010)));
        q.push_back(mk(4'd4, rnd(), po(8'b0000_0110, hw, 2'b00, 2'b00, 1'b0, 3'b010)));
      end else begin
        for (int i = 0; i < mw; i++)
          q.push_back(mk(4'd5, 1'b0, po(8'b0101_0000, hw, 2'b00, 2'b00, 1'b0, 3'b010)));
        q.push_back(mk(4'd5, 1'b1, po(8'b0101_0000, hw, 2'b00, 2'b00, 1'b0, 3'b010)));
      end
    end else if (is_r) begin
      q.push_back(mk(4'd6, rnd(), po(8'b0000_0001, 1'b0, 2'b00, 2'b00, sh, alu)));
      q.push_back(mk(4'd7, rnd(), po(8'b0000_1010, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010)));
    end else if (op == 6'h04) begin
      q.push_back(mk(4'd8, rnd(), po({zero, 7'b000_0001}, 1'b0, 2'b00, 2'b01, 1'b0, 3'b110)));
    end else if (op == 6'h08) begin
      q.push_back(mk(4'd9, rnd(), po(8'b0000_0001, 1'b0, 2'b10, 2'b00, 1'b0, 3'b010)));
      q.push_back(mk(4'd10, rnd(), po(8'b0000_0010, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010)));
    end else if (op == 6'h02) begin
      q.push_back(mk(4'd11, rnd(), po(8'b1000_0000, 1'b0, 2'b00, 2'b10, 1'b0, 3'b010)));
    end else begin
      ill = 1'b1;
    end
  endtask

  // Entered and left at posedge+1 with the DUT in FETCH.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic zero, input int fw, input int mw);
    bit    ill;
    step_t s;
    build(op, fn, zero, fw, mw, ill);
    foreach (q[i]) begin
      s        = q[i];
      Opcode   = op;
      Funct    = fn;
      Zero     = zero;
      MemReady = s.rdy;
      #1;
      n_total++;
      if (State !== s.st || obs !== s.o || Illegal !== illegal_m)
        $display("FAIL %s step %0d: got state=%0d ctl=%h illegal=%b, want state=%0d ctl=%h illegal=%b",
                 name, i, State, obs, Illegal, s.st, s.o, illegal_m);
      else n_pass++;
      @(posedge clk);
      #1;
      if (s.st == 4'd1 && ill) illegal_m = 1'b1;
    end
    MemReady = 1'b0;
    #1;
    n_total++;
    if (State !== 4'd0) $display("FAIL %s end: got state=%0d, want 0", name, State);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b0; MemReady = 1'b0; Zero = 1'b0; Opcode = 6'h00; Funct = 6'h20;
    #12;
    n_total++;
    if (State !== 4'd0 || Illegal !== 1'b0 ||
        obs !== po(8'b0, 1'b0, 2'b01, 2'b00, 1'b0, 3'b010))
      $display("FAIL reset: got state=%0d illegal=%b ctl=%h, want 0 0 %h", State, Illegal, obs,
               po(8'b0, 1'b0, 2'b01, 2'b00, 1'b0, 3'b010));
    else n_pass++;
    reset = 1'b1;
    illegal_m = 1'b0;
    @(posedge clk);
    #1;
    n_total++;
    if (State !== 4'd0) $display("FAIL reset_hold: got state=%0d, want 0", State);
    else n_pass++;
  endtask

  task automatic test_rtype();
    run_instr("add", 6'h00, 6'h20, 1'b0, 0, 0);
    run_instr("sub", 6'h00, 6'h22, 1'b1, 1, 0);
    run_instr("sll", 6'h00, 6'h00, 1'b0, 0, 0);
    run_instr("srl", 6'h00, 6'h02, 1'b0, 2, 0);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait", 6'h23, 6'h11, 1'b0, 0, 2);
    run_instr("lh", 6'h21, 6'h05, 1'b0, 1, 1);
  endtask

  task automatic test_sh();
    run_instr("sh", 6'h29, 6'h00, 1'b0, 0, 0);
    run_instr("sw_wait", 6'h2b, 6'h00, 1'b0, 0, 2);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", 6'h04, 6'h00, 1'b1, 0, 0);
    run_instr("beq_not_taken", 6'h04, 6'h00, 1'b0, 0, 0);
    run_instr("addi", 6'h08, 6'h3f, 1'b0, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal_op", 6'h3f, 6'h20, 1'b0, 0, 0);
    run_instr("j_after_illegal", 6'h02, 6'h00, 1'b0, 0, 0);
    n_total++;
    if (Illegal !== 1'b1) $display("FAIL illegal_sticky: got %b, want 1", Illegal);
    else n_pass++;
    reset = 1'b0;
    #2;
    n_total++;
    if (Illegal !== 1'b0 || State !== 4'd0)
      $display("FAIL illegal_clear: got illegal=%b state=%0d, want 0 0", Illegal, State);
    else n_pass++;
    reset = 1'b1;
    illegal_m = 1'b0;
    @(posedge clk);
    #1;
    run_instr("rtype_bad_funct", 6'h00, 6'h3e, 1'b0, 0, 0);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    illegal_m = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midwrite();
    Opcode = 6'h2b; Funct = 6'h00; Zero = 1'b0; MemReady = 1'b1;
    @(posedge clk); #1;
    MemReady = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_total++;
    if (State !== 4'd5 || MemWrite !== 1'b1)
      $display("FAIL midwrite_pre: got state=%0d memwrite=%b, want 5 1", State, MemWrite);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if (State !== 4'd0 || MemWrite !== 1'b0 ||
        obs !== po(8'b0, 1'b0, 2'b01, 2'b00, 1'b0, 3'b010))
      $display("FAIL midwrite_reset: got state=%0d memwrite=%b ctl=%h, want 0 0 %h", State,
               MemWrite, obs, po(8'b0, 1'b0, 2'b01, 2'b00, 1'b0, 3'b010));
    else n_pass++;
    reset = 1'b1;
    illegal_m = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (State !== 4'd0) $display("FAIL midwrite_after: got state=%0d, want 0", State);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [5:0] ops[14]   = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                              6'h23, 6'h21, 6'h2b, 6'h29, 6'h04, 6'h08, 6'h02};
    logic [5:0] fns[14]   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02,
                              6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    logic [5:0] op, fn;
    int         k;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        k  = $urandom_range(0, 13);
        op = ops[k];
        fn = (op == 6'h00) ? fns[k] : 6'($urandom);
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      run_instr($sformatf("rand%0d_op%h_fn%h", n, op, fn), op, fn, rnd(),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sh();
    test_beq();
    test_illegal();
    test_reset_midwrite();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
